// File: rtl/sdram_arb_pkg.sv
// ============================================================================
//  Module  : sdram_arb_pkg
//  Purpose : Shared types, default widths and width helpers for the SDRAM
//            round-robin arbiter and its ID FIFO.
//  Contents: arb_state_e (ST_IDLE, ST_CMD), DEF_* default parameter values,
//            id_width()/cnt_width() helpers for clog2-derived widths.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package sdram_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CMD  = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_AW       = 22;
  localparam int DEF_DW       = 16;
  localparam int DEF_MAX_PEND = 4;
  localparam int DEF_LOCK_MAX = 8;

  // Width of an index into n entries (at least one bit).
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must hold the value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_arb_id_fifo.sv
// ============================================================================
//  Module  : sdram_arb_id_fifo
//  Purpose : Small synchronous FIFO holding the requester ID of every read
//            that has been accepted but whose data has not yet returned.
//  Ports   : clk, reset (async, active-high)
//            push/push_data  - write an ID (ignored when full unless popping)
//            pop/pop_data    - remove the head ID (ignored when empty)
//            full/empty      - occupancy flags
//  Notes   : DEPTH must be a power of two >= 2; push and pop in the same cycle
//            are both performed and leave the occupancy unchanged.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sdram_arb_id_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_PEND,
  parameter int WIDTH = id_width(DEF_NUM_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = id_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  // A pop frees the slot the simultaneous push needs, so a full FIFO may push.
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/sdram_rr_arbiter.sv
// ============================================================================
//  Module  : sdram_rr_arbiter
//  Purpose : Round-robin arbiter sharing one Avalon-MM master into the SDRAM
//            controller among NUM_REQ requesters. One command in flight at a
//            time; up to MAX_PEND pipelined reads outstanding, with returned
//            data steered back to the issuer through an ID FIFO.
//  Ports   : clk, reset (async, active-high)
//            req_read/req_write/req_addr/req_wdata/req_be  - requester side
//            req_lock (only with SDRAM_ARB_LOCK_EN)        - keep the grant
//            req_waitrequest - low only in the cycle a request is accepted
//            rsp_readdata/rsp_valid - registered read return, one-hot owner
//            m_* - master interface towards the SDRAM controller
//            err_orphan - sticky: read data arrived with no read outstanding
//  Config  : define SDRAM_ARB_LOCK_EN to add req_lock; a locked requester
//            keeps the pointer for up to LOCK_MAX consecutive accepts.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sdram_rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MAX_PEND = DEF_MAX_PEND,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_read,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*AW-1:0]       req_addr,
  input  logic [NUM_REQ*DW-1:0]       req_wdata,
  input  logic [NUM_REQ*(DW/8)-1:0]   req_be,
`ifdef SDRAM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]          req_lock,
`endif
  output logic [NUM_REQ-1:0]          req_waitrequest,
  output logic [DW-1:0]               rsp_readdata,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [AW-1:0]               m_address,
  output logic                        m_read,
  output logic                        m_write,
  output logic [DW-1:0]               m_writedata,
  output logic [(DW/8)-1:0]           m_byteenable,
  input  logic                        m_waitrequest,
  input  logic [DW-1:0]               m_readdata,
  input  logic                        m_readdatavalid,
  output logic                        err_orphan
);

  localparam int BEW  = DW / 8;
  localparam int ID_W = id_width(NUM_REQ);
  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  // Elaboration-time sanity checks on the configuration.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("sdram_rr_arbiter: NUM_REQ must be 2..8");
  end
  if (MAX_PEND < 2 || (MAX_PEND & (MAX_PEND - 1)) != 0) begin : g_bad_max_pend
    $error("sdram_rr_arbiter: MAX_PEND must be a power of two >= 2");
  end
  if (LOCK_MAX < 1) begin : g_bad_lock_max
    $error("sdram_rr_arbiter: LOCK_MAX must be >= 1");
  end

  // --------------------------------------------------------------------------
  // Unpack the per-requester payload buses
  // --------------------------------------------------------------------------
  logic [AW-1:0]  addr_arr  [NUM_REQ];
  logic [DW-1:0]  wdata_arr [NUM_REQ];
  logic [BEW-1:0] be_arr    [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*AW +: AW];
    assign wdata_arr[i] = req_wdata[i*DW +: DW];
    assign be_arr[i]    = req_be[i*BEW +: BEW];
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  arb_state_e      state;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_inc;

`ifdef SDRAM_ARB_LOCK_EN
  localparam int LCW = cnt_width(LOCK_MAX);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_MAX - 1);
  logic [LCW-1:0] lock_cnt;
`endif

  // ID FIFO interface
  logic            fifo_push;
  logic            fifo_full;
  logic            fifo_empty;
  logic [ID_W-1:0] fifo_head;

  logic accept;

  assign accept  = (state == ST_CMD) && !m_waitrequest;
  assign ptr_inc = (grant == LAST_ID) ? '0 : grant + 1'b1;

  // --------------------------------------------------------------------------
  // Round-robin selection: first eligible requester at or above the pointer,
  // wrapping around. A write always qualifies; a read only while there is room
  // to record its ID. A requester raising both is treated as a write.
  // --------------------------------------------------------------------------
  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [ID_W-1:0]    winner;
  logic [ID_W:0]      scan_idx;

  always_comb begin
    eligible = req_write | (req_read & {NUM_REQ{~fifo_full}});
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr} + (ID_W + 1)'(k);
      if (scan_idx >= NUM_REQ_W) scan_idx = scan_idx - NUM_REQ_W;
      if (!found && eligible[scan_idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[ID_W-1:0];
      end
    end
  end

  // The accept is combinational on m_waitrequest so the requester sees it in
  // the same cycle the slave takes the command.
  always_comb begin
    req_waitrequest = '1;
    if (accept) req_waitrequest[grant] = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Command FSM and read-return steering
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      grant        <= '0;
      ptr          <= '0;
      m_address    <= '0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_writedata  <= '0;
      m_byteenable <= '0;
      rsp_valid    <= '0;
      rsp_readdata <= '0;
      err_orphan   <= 1'b0;
`ifdef SDRAM_ARB_LOCK_EN
      lock_cnt     <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      if (m_readdatavalid) begin
        if (!fifo_empty) begin
          rsp_valid    <= NUM_REQ'(1) << fifo_head;
          rsp_readdata <= m_readdata;
        end else begin
          err_orphan <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (found) begin
            grant        <= winner;
            m_address    <= addr_arr[winner];
            m_writedata  <= wdata_arr[winner];
            m_byteenable <= be_arr[winner];
            m_write      <= req_write[winner];
            m_read       <= ~req_write[winner];
            state        <= ST_CMD;
          end
        end
        ST_CMD: begin
          // m_* hold their values while the slave stalls.
          if (!m_waitrequest) begin
            m_read  <= 1'b0;
            m_write <= 1'b0;
            state   <= ST_IDLE;
`ifdef SDRAM_ARB_LOCK_EN
            // A locked accept keeps the pointer on the grantee, but only
            // LOCK_MAX times in a row before it is forced onward.
            if (req_lock[grant] && (lock_cnt != LOCK_LAST)) begin
              ptr      <= grant;
              lock_cnt <= lock_cnt + 1'b1;
            end else begin
              ptr      <= ptr_inc;
              lock_cnt <= '0;
            end
`else
            ptr <= ptr_inc;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fifo_push = accept & m_read;

  sdram_arb_id_fifo #(
    .DEPTH (MAX_PEND),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (grant),
    .pop       (m_readdatavalid),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_sdram_rr_arbiter.sv
// ============================================================================
//  Module  : tb_sdram_rr_arbiter
//  Purpose : Self-checking bench for sdram_rr_arbiter: directed scenarios plus
//            a randomized run against a transaction-level reference model.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sdram_rr_arbiter;

  localparam int N   = 4;
  localparam int AW  = 22;
  localparam int DW  = 16;
  localparam int BEW = 2;
  localparam int MP  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_read, req_write, req_lock;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N*BEW-1:0]  req_be;
  logic [N-1:0]      req_waitrequest;
  logic [DW-1:0]     rsp_readdata;
  logic [N-1:0]      rsp_valid;
  logic [AW-1:0]     m_address;
  logic              m_read, m_write;
  logic [DW-1:0]     m_writedata;
  logic [BEW-1:0]    m_byteenable;
  logic              m_waitrequest;
  logic [DW-1:0]     m_readdata;
  logic              m_readdatavalid;
  logic              err_orphan;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  sdram_rr_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .MAX_PEND(MP), .LOCK_MAX(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_read        (req_read),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_be          (req_be),
`ifdef SDRAM_ARB_LOCK_EN
    .req_lock        (req_lock),
`endif
    .req_waitrequest (req_waitrequest),
    .rsp_readdata    (rsp_readdata),
    .rsp_valid       (rsp_valid),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_byteenable    (m_byteenable),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .err_orphan      (err_orphan)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Clears all inputs, pulses reset and returns just after a rising edge,
  // so the caller's first drive is seen at the end of "cycle 1".
  task automatic do_reset();
    req_read = '0; req_write = '0; req_lock = '0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    req_write[3] = 1'b1; req_addr[3*AW +: AW] = 22'h3ABCD; req_wdata[3*DW +: DW] = 16'h1357;
    req_be[3*BEW +: BEW] = 2'b11; m_waitrequest = 1'b1;
    @(posedge clk); @(negedge clk);
    compared++;
    if (m_write !== 1'b1) begin
      mismatched++; $display("FAIL pre_reset_write: got %b want 1", m_write);
    end
    #1 reset = 1'b1;
    #1;
    compared++;
    if (req_waitrequest !== 4'hF || m_read !== 1'b0 || m_write !== 1'b0 || m_address !== '0 ||
        m_writedata !== '0 || m_byteenable !== '0 || rsp_valid !== '0 || rsp_readdata !== '0 ||
        err_orphan !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: wr=%h rd=%b w=%b a=%h wd=%h be=%b rv=%h rd=%h err=%b want all idle",
               req_waitrequest, m_read, m_write, m_address, m_writedata, m_byteenable,
               rsp_valid, rsp_readdata, err_orphan);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_single_write();
    do_reset();
    req_write[0] = 1'b1; req_addr[0 +: AW] = 22'h10; req_wdata[0 +: DW] = 16'hBEEF;
    req_be[0 +: BEW] = 2'b11;
    @(negedge clk);
    compared++;
    if (m_write !== 1'b0) begin
      mismatched++; $display("FAIL write_cycle1: m_write=%b want 0", m_write);
    end
    @(posedge clk); @(negedge clk);
    compared++;
    if (m_write !== 1'b1 || m_address !== 22'h10 || m_writedata !== 16'hBEEF ||
        m_byteenable !== 2'b11 || req_waitrequest !== 4'b1110) begin
      mismatched++;
      $display("FAIL write_cycle2: w=%b a=%h d=%h be=%b wr=%b want 1/10/beef/11/1110",
               m_write, m_address, m_writedata, m_byteenable, req_waitrequest);
    end
    // Pointer is now 1: with 0 and 1 both requesting, 1 must win.
    @(posedge clk); #1;
    req_addr[0 +: AW] = 22'h20; req_addr[AW +: AW] = 22'h21; req_write[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    compared++;
    if (m_write !== 1'b1 || m_address !== 22'h21 || req_waitrequest !== 4'b1101) begin
      mismatched++;
      $display("FAIL pointer_after_write: w=%b a=%h wr=%b want 1/21/1101",
               m_write, m_address, req_waitrequest);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_round_robin();
    int cyc = 0, n_acc = 0;
    int due[$];
    int ids[$];
    logic [N-1:0]  exp_now = '0, exp_nxt = '0;
    logic [DW-1:0] dat_now = '0, dat_nxt = '0;
    int id;
    do_reset();
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(i);
    for (int c = 0; c < 24; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      cyc++;
      req_read = (c < 14) ? 4'hF : 4'h0;
      m_readdatavalid = 1'b0;
      if (due.size() > 0 && due[0] == cyc) begin
        void'(due.pop_front());
        id = ids.pop_front();
        m_readdatavalid = 1'b1;
        m_readdata = DW'($urandom);
        exp_nxt = N'(1) << id;
        dat_nxt = m_readdata;
      end
      @(negedge clk);
      compared++;
      if (rsp_valid !== exp_now || (exp_now != '0 && rsp_readdata !== dat_now)) begin
        mismatched++;
        $display("FAIL rr_rsp: rv=%b rd=%h want %b/%h", rsp_valid, rsp_readdata, exp_now, dat_now);
      end
      exp_now = exp_nxt; dat_now = dat_nxt; exp_nxt = '0;
      if (m_read && !m_waitrequest) begin
        compared++;
        if (req_waitrequest !== ~(N'(1) << (n_acc % N)) || m_address !== AW'(n_acc % N)) begin
          mismatched++;
          $display("FAIL rr_order: accept %0d wr=%b a=%h want requester %0d",
                   n_acc, req_waitrequest, m_address, n_acc % N);
        end
        due.push_back(cyc + 2);
        ids.push_back(n_acc % N);
        n_acc++;
      end
    end
    compared++;
    if (n_acc < 5) begin
      mismatched++; $display("FAIL rr_count: got %0d accepts want >= 5", n_acc);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_stall();
    int lows = 0;
    do_reset();
    m_waitrequest = 1'b1;
    req_write[1] = 1'b1; req_addr[AW +: AW] = 22'h155; req_wdata[DW +: DW] = 16'h1234;
    req_be[BEW +: BEW] = 2'b01;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      compared++;
      if (m_write !== 1'b1 || m_address !== 22'h155 || m_writedata !== 16'h1234 ||
          m_byteenable !== 2'b01 || req_waitrequest !== 4'hF) begin
        mismatched++;
        $display("FAIL stall_hold: k=%0d w=%b a=%h d=%h be=%b wr=%b", k, m_write, m_address,
                 m_writedata, m_byteenable, req_waitrequest);
      end
    end
    @(posedge clk); #1 m_waitrequest = 1'b0;
    @(negedge clk);
    if (req_waitrequest !== 4'hF) lows++;
    compared++;
    if (req_waitrequest !== 4'b1101 || m_write !== 1'b1) begin
      mismatched++; $display("FAIL stall_accept: wr=%b w=%b want 1101/1", req_waitrequest, m_write);
    end
    @(posedge clk); #1 req_write = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (req_waitrequest !== 4'hF) lows++;
      @(posedge clk); #1;
    end
    compared++;
    if (lows !== 1 || m_write !== 1'b0) begin
      mismatched++; $display("FAIL stall_single_pulse: pulses=%0d w=%b want 1/0", lows, m_write);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_fifo_full();
    int n_acc = 0, waited = 0;
    logic got;
    do_reset();
    req_read[0] = 1'b1; req_addr[0 +: AW] = 22'h44;
    while (n_acc < MP && waited < 30) begin
      @(negedge clk);
      if (m_read && !m_waitrequest && req_waitrequest === 4'b1110) n_acc++;
      waited++;
      if (n_acc < MP) begin @(posedge clk); #1; end
    end
    compared++;
    if (n_acc !== MP) begin
      mismatched++; $display("FAIL full_fill: got %0d accepts want %0d", n_acc, MP);
    end
    @(posedge clk); #1;
    req_write[2] = 1'b1; req_addr[2*AW +: AW] = 22'h2AA; req_wdata[2*DW +: DW] = 16'hCAFE;
    @(negedge clk);
    compared++;
    if (m_read !== 1'b0 || m_write !== 1'b0) begin
      mismatched++; $display("FAIL full_idle: r=%b w=%b want 0/0", m_read, m_write);
    end
    @(posedge clk); @(negedge clk);
    compared++;
    if (m_write !== 1'b1 || m_address !== 22'h2AA || req_waitrequest !== 4'b1011) begin
      mismatched++;
      $display("FAIL full_write_granted: w=%b a=%h wr=%b want 1/2aa/1011", m_write, m_address,
               req_waitrequest);
    end
    @(posedge clk); #1 req_write = '0;
    got = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (m_read) got = 1'b1;
      @(posedge clk); #1;
    end
    compared++;
    if (got !== 1'b0) begin
      mismatched++; $display("FAIL full_read_blocked: read granted=%b want 0", got);
    end
    m_readdatavalid = 1'b1; m_readdata = 16'h5A5A;
    @(posedge clk); #1 m_readdatavalid = 1'b0;
    @(negedge clk);
    compared++;
    if (rsp_valid !== 4'b0001 || rsp_readdata !== 16'h5A5A) begin
      mismatched++; $display("FAIL full_return: rv=%b rd=%h want 0001/5a5a", rsp_valid, rsp_readdata);
    end
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(posedge clk); @(negedge clk);
      if (m_read && req_waitrequest === 4'b1110) got = 1'b1;
    end
    compared++;
    if (got !== 1'b1) begin
      mismatched++; $display("FAIL full_read_after_pop: read granted=%b want 1", got);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_orphan();
    do_reset();
    m_readdatavalid = 1'b1; m_readdata = 16'h7777;
    @(posedge clk); #1 m_readdatavalid = 1'b0;
    @(negedge clk);
    compared++;
    if (rsp_valid !== '0 || err_orphan !== 1'b1) begin
      mismatched++; $display("FAIL orphan_set: rv=%b err=%b want 0000/1", rsp_valid, err_orphan);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    compared++;
    if (err_orphan !== 1'b1) begin
      mismatched++; $display("FAIL orphan_sticky: err=%b want 1", err_orphan);
    end
  endtask

`ifdef SDRAM_ARB_LOCK_EN
  // --------------------------------------------------------------------------
  task automatic test_lock();
    int n2 = 0;
    logic got0 = 1'b0;
    do_reset();
    req_lock[2] = 1'b1; req_write[2] = 1'b1; req_addr[2*AW +: AW] = 22'h22;
    @(posedge clk); #1;
    req_write[0] = 1'b1; req_addr[0 +: AW] = 22'h00;
    for (int k = 0; k < 40 && !got0; k++) begin
      @(negedge clk);
      if (m_write && !m_waitrequest) begin
        if (req_waitrequest === 4'b1011) n2++;
        else if (req_waitrequest === 4'b1110) got0 = 1'b1;
      end
      @(posedge clk); #1;
    end
    compared++;
    if (n2 !== 8 || got0 !== 1'b1) begin
      mismatched++; $display("FAIL lock_limit: req2 accepts=%0d req0 granted=%b want 8/1", n2, got0);
    end
  endtask
`endif

  // --------------------------------------------------------------------------
  // Randomized run. The model works at transaction level: which requesters
  // hold a request, a round-robin pointer, one command in flight, and an ID
  // queue of outstanding reads.
  // --------------------------------------------------------------------------
  int             act  [N];
  int             kind [N];   // 0/1 read, 2 write, 3 read+write (served as write)
  logic [AW-1:0]  t_addr [N];
  logic [DW-1:0]  t_data [N];
  logic [BEW-1:0] t_be   [N];

  task automatic test_random();
    int  cyc = 0, mptr = 0, g = 0, w;
    logic midle = 1'b1, gen = 1'b1, rdv_now;
    logic [DW-1:0] rdv_dat = '0;
    int  idq[$];
    int  sdue[$];
    logic [N-1:0]  exp_rv = '0;
    logic [DW-1:0] exp_rd = '0;
    logic          c_wr = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_data = '0;
    logic [BEW-1:0] c_be = '0;
    do_reset();
    for (int i = 0; i < N; i++) act[i] = 0;
    for (int c = 0; c < 3400; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      cyc++;
      if (c == 3000) gen = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (act[i] == 0 && gen && $urandom_range(0, 1) == 1) begin
          act[i] = 1; kind[i] = int'($urandom_range(0, 3));
          t_addr[i] = AW'($urandom); t_data[i] = DW'($urandom); t_be[i] = BEW'($urandom);
        end
        req_read[i]  = (act[i] != 0) && (kind[i] != 2);
        req_write[i] = (act[i] != 0) && (kind[i] >= 2);
        req_addr[i*AW +: AW]    = t_addr[i];
        req_wdata[i*DW +: DW]   = t_data[i];
        req_be[i*BEW +: BEW]    = t_be[i];
      end
      m_waitrequest = ($urandom_range(0, 3) == 0);
      rdv_now = 1'b0;
      if (sdue.size() > 0 && sdue[0] <= cyc && $urandom_range(0, 3) != 0) begin
        void'(sdue.pop_front());
        rdv_now = 1'b1; rdv_dat = DW'($urandom);
      end
      m_readdatavalid = rdv_now; m_readdata = rdv_dat;

      @(negedge clk);
      compared++;
      if (rsp_valid !== exp_rv || (exp_rv != '0 && rsp_readdata !== exp_rd)) begin
        mismatched++;
        $display("FAIL rand_rsp: cyc=%0d rv=%b rd=%h want %b/%h", cyc, rsp_valid, rsp_readdata,
                 exp_rv, exp_rd);
      end
      compared++;
      if (midle) begin
        if (m_read !== 1'b0 || m_write !== 1'b0 || req_waitrequest !== 4'hF) begin
          mismatched++;
          $display("FAIL rand_idle: cyc=%0d r=%b w=%b wr=%b want 0/0/1111", cyc, m_read, m_write,
                   req_waitrequest);
        end
      end else begin
        if (m_write !== c_wr || m_read !== !c_wr || m_address !== c_addr ||
            (c_wr && (m_writedata !== c_data || m_byteenable !== c_be)) ||
            req_waitrequest !== (m_waitrequest ? 4'hF : ~(N'(1) << g))) begin
          mismatched++;
          $display("FAIL rand_cmd: cyc=%0d g=%0d r=%b w=%b a=%h d=%h be=%b wr=%b want w=%b a=%h d=%h be=%b",
                   cyc, g, m_read, m_write, m_address, m_writedata, m_byteenable,
                   req_waitrequest, c_wr, c_addr, c_data, c_be);
        end
      end

      if (midle) begin
        w = -1;
        for (int k = 0; k < N && w < 0; k++) begin
          int i;
          i = (mptr + k) % N;
          if (act[i] != 0 && (kind[i] >= 2 || idq.size() < MP)) w = i;
        end
        if (w >= 0) begin
          g = w; midle = 1'b0;
          c_wr = (kind[w] >= 2); c_addr = t_addr[w]; c_data = t_data[w]; c_be = t_be[w];
        end
      end else if (!m_waitrequest) begin
        act[g] = 0;
        mptr = (g + 1) % N;
        midle = 1'b1;
      end
      exp_rv = '0;
      if (rdv_now) begin
        exp_rv = N'(1) << idq.pop_front();
        exp_rd = rdv_dat;
      end
      if (midle && !c_wr && act[g] == 0 && !m_waitrequest && m_read) begin
        idq.push_back(g);
        sdue.push_back(cyc + 1 + int'($urandom_range(0, 3)));
        c_wr = 1'b1;  // record the push only once
      end
    end
    compared++;
    if (idq.size() != 0 || !midle) begin
      mismatched++;
      $display("FAIL rand_drain: outstanding=%0d idle=%b want 0/1", idq.size(), midle);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_stall();
    test_fifo_full();
    test_orphan();
`ifdef SDRAM_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
